// File: rtl/bomberman_frame_sequencer.sv
// bomberman_frame_sequencer: per-frame draw sequencer (stage, 121 tiles, p1, p2) plus frame-tick player strobes.
// Optional macro PAUSE_EN adds a pause input that freezes strobes and the move divider.
module bomberman_frame_sequencer #(
    parameter int FRAME_CYCLES = 833333,
    parameter int MOVE_DIV     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       finished,
    input  logic       all_tiles_drawn,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p1_bomb_btn,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       p2_bomb_btn,
`ifdef PAUSE_EN
    input  logic       pause,
`endif
    output logic [1:0] memory_select,
    output logic       copy_enable,
    output logic       tc_enable,
    output logic       player_reset,
    output logic       stage_reset,
    output logic       draw_stage,
    output logic       draw_t,
    output logic       draw_p1,
    output logic       draw_p2,
    output logic       p1_xmov,
    output logic       p1_xdir,
    output logic       p1_ymov,
    output logic       p1_ydir,
    output logic       p1_bomb,
    output logic       p2_xmov,
    output logic       p2_xdir,
    output logic       p2_ymov,
    output logic       p2_ydir,
    output logic       p2_bomb,
    output logic       frame_done,
    output logic       frame_overrun
);
    localparam int CW = ($clog2(FRAME_CYCLES) > 20) ? $clog2(FRAME_CYCLES) : 20;

    typedef enum logic [3:0] {
        INIT, STAGE_GO, STAGE_WAIT, TILE_GO, TILE_WAIT, TILE_STEP, TILE_CHECK,
        P1_GO, P1_WAIT, P2_GO, P2_WAIT, FRAME_WAIT, UPDATE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    div_q, div_d;
    logic          tick_pending_q, tick_pending_d;
    logic          frame_overrun_q, frame_overrun_d;
    logic [1:0]    mem_q, mem_d;
    logic          copy_q, copy_d, tc_q, tc_d, init_q, init_d, done_q, done_d;
    logic [3:0]    draw_q, draw_d;
    logic [1:0]    xmov_q, xmov_d, xdir_q, xdir_d, ymov_q, ymov_d, ydir_q, ydir_d, bomb_q, bomb_d;
    logic          tick, leave_wait, advance, strobe, pause_i;

`ifdef PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    always_comb begin
        tick            = cnt_q == CW'(FRAME_CYCLES - 1);
        cnt_d           = tick ? '0 : cnt_q + 1'b1;
        leave_wait      = (state_q == FRAME_WAIT) && tick_pending_q;
        tick_pending_d  = tick | (tick_pending_q & ~leave_wait);
        frame_overrun_d = frame_overrun_q | (tick & tick_pending_q & (state_q != FRAME_WAIT));
        advance         = leave_wait & ~pause_i;
        strobe          = advance & (div_q == 4'd0);
        div_d           = !advance ? div_q : (div_q == 4'(MOVE_DIV - 1)) ? 4'd0 : div_q + 4'd1;
        state_d         = state_q;
        case (state_q)
            INIT:       state_d = STAGE_GO;
            STAGE_GO:   state_d = STAGE_WAIT;
            STAGE_WAIT: state_d = finished ? TILE_GO : STAGE_WAIT;
            TILE_GO:    state_d = TILE_WAIT;
            TILE_WAIT:  state_d = finished ? TILE_STEP : TILE_WAIT;
            TILE_STEP:  state_d = TILE_CHECK;
            TILE_CHECK: state_d = all_tiles_drawn ? P1_GO : TILE_GO;
            P1_GO:      state_d = P1_WAIT;
            P1_WAIT:    state_d = finished ? P2_GO : P1_WAIT;
            P2_GO:      state_d = P2_WAIT;
            P2_WAIT:    state_d = finished ? FRAME_WAIT : P2_WAIT;
            FRAME_WAIT: state_d = tick_pending_q ? UPDATE : FRAME_WAIT;
            UPDATE:     state_d = STAGE_GO;
            default:    state_d = INIT;
        endcase
        // Outputs are decoded from the next state so they line up with the registered state
        copy_d    = state_d inside {STAGE_GO, TILE_GO, P1_GO, P2_GO};
        tc_d      = state_d == TILE_STEP;
        init_d    = state_d == INIT;
        done_d    = (state_q == P2_WAIT) && finished;
        draw_d[0] = state_d inside {STAGE_GO, STAGE_WAIT};
        draw_d[1] = state_d inside {TILE_GO, TILE_WAIT};
        draw_d[2] = state_d inside {P1_GO, P1_WAIT};
        draw_d[3] = state_d inside {P2_GO, P2_WAIT};
        mem_d     = draw_d[3] ? 2'd3 : draw_d[2] ? 2'd2 : draw_d[1] ? 2'd1 : 2'd0;
        xmov_d    = strobe ? {p2_left ^ p2_right, p1_left ^ p1_right} : 2'b00;
        ymov_d    = strobe ? {p2_up ^ p2_down, p1_up ^ p1_down} : 2'b00;
        bomb_d    = strobe ? {p2_bomb_btn, p1_bomb_btn} : 2'b00;
        xdir_d    = strobe ? {p2_right, p1_right} : xdir_q;
        ydir_d    = strobe ? {p2_down, p1_down} : ydir_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= INIT;
            cnt_q           <= '0;
            div_q           <= 4'd0;
            tick_pending_q  <= 1'b0;
            frame_overrun_q <= 1'b0;
            mem_q           <= 2'd0;
            copy_q          <= 1'b0;
            tc_q            <= 1'b0;
            init_q          <= 1'b1;
            done_q          <= 1'b0;
            draw_q          <= 4'd0;
            xmov_q          <= 2'b00;
            xdir_q          <= 2'b00;
            ymov_q          <= 2'b00;
            ydir_q          <= 2'b00;
            bomb_q          <= 2'b00;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            div_q           <= div_d;
            tick_pending_q  <= tick_pending_d;
            frame_overrun_q <= frame_overrun_d;
            mem_q           <= mem_d;
            copy_q          <= copy_d;
            tc_q            <= tc_d;
            init_q          <= init_d;
            done_q          <= done_d;
            draw_q          <= draw_d;
            xmov_q          <= xmov_d;
            xdir_q          <= xdir_d;
            ymov_q          <= ymov_d;
            ydir_q          <= ydir_d;
            bomb_q          <= bomb_d;
        end
    end

    assign memory_select = mem_q;
    assign copy_enable   = copy_q;
    assign tc_enable     = tc_q;
    assign player_reset  = init_q;
    assign stage_reset   = init_q;
    assign draw_stage    = draw_q[0];
    assign draw_t        = draw_q[1];
    assign draw_p1       = draw_q[2];
    assign draw_p2       = draw_q[3];
    assign p1_xmov       = xmov_q[0];
    assign p1_xdir       = xdir_q[0];
    assign p1_ymov       = ymov_q[0];
    assign p1_ydir       = ydir_q[0];
    assign p1_bomb       = bomb_q[0];
    assign p2_xmov       = xmov_q[1];
    assign p2_xdir       = xdir_q[1];
    assign p2_ymov       = ymov_q[1];
    assign p2_ydir       = ydir_q[1];
    assign p2_bomb       = bomb_q[1];
    assign frame_done    = done_q;
    assign frame_overrun = frame_overrun_q;
endmodule
